// File: rtl/azadi_rst_boot_ctrl.sv
// Reset/boot sequencer: pad synchronisers, PLL-lock debounce, hold-off FSM and frozen boot select.
// Define RST_CAUSE_EN to build the rst_cause_o register; otherwise rst_cause_o is tied to 2'b00.
module azadi_rst_boot_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned RST_HOLD    = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rst_req_i,
  input  logic       pll_lock_i,
  input  logic [1:0] boot_sel_i,
  output logic       sys_rst_no,
  output logic       pll_lock_o,
  output logic [1:0] boot_sel_o,
  output logic       ready_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned LFW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned HW  = $clog2(RST_HOLD + 1);
  localparam logic [LFW-1:0] LF_MAX    = LFW'(LOCK_FILTER);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOCK,
    HOLD,
    RUN
  } state_e;

  logic [SYNC_STAGES-1:0]      req_sync_q;
  logic [SYNC_STAGES-1:0]      lock_sync_q;
  logic [SYNC_STAGES-1:0][1:0] bsel_sync_q;
  logic                        req_s;
  logic                        lock_s;
  logic [1:0]                  bsel_s;

  logic [LFW-1:0] lock_cnt_q, lock_cnt_d;
  logic           pll_lock_q, pll_lock_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]     boot_sel_q, boot_sel_d;
  state_e         state_q, state_d;

  assign req_s  = req_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign bsel_s = bsel_sync_q[SYNC_STAGES-1];

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lock_s) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LF_MAX) begin
      lock_cnt_d = lock_cnt_q + LFW'(1);
    end
  end

  // Gated by lock_s so a lock drop is seen one cycle after the synchroniser output falls.
  assign pll_lock_d = lock_s && (lock_cnt_q == LF_MAX);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    boot_sel_d = boot_sel_q;
    unique case (state_q)
      IDLE: begin
        if (!req_s) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        hold_cnt_d = '0;
        if (pll_lock_q && !req_s) state_d = HOLD;
      end
      HOLD: begin
        if (req_s || !pll_lock_q) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          boot_sel_d = bsel_s;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      RUN: begin
        if (req_s || !pll_lock_q) state_d = WAIT_LOCK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_sync_q  <= '0;
      lock_sync_q <= '0;
      bsel_sync_q <= '0;
      lock_cnt_q  <= '0;
      pll_lock_q  <= 1'b0;
      hold_cnt_q  <= '0;
      boot_sel_q  <= '0;
      state_q     <= IDLE;
    end else begin
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], rst_req_i};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock_i};
      bsel_sync_q <= {bsel_sync_q[SYNC_STAGES-2:0], boot_sel_i};
      lock_cnt_q  <= lock_cnt_d;
      pll_lock_q  <= pll_lock_d;
      hold_cnt_q  <= hold_cnt_d;
      boot_sel_q  <= boot_sel_d;
      state_q     <= state_d;
    end
  end

`ifdef RST_CAUSE_EN
  logic       run_exit;
  logic [1:0] cause_q;

  assign run_exit = (state_q == RUN) && (req_s || !pll_lock_q);

  // Lock-loss cause also looks at lock_s so a pad request racing a lock drop records both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_q <= '0;
    end else if (run_exit) begin
      cause_q <= {(!pll_lock_q || !lock_s), req_s};
    end
  end

  assign rst_cause_o = cause_q;
`else
  assign rst_cause_o = 2'b00;
`endif

  assign sys_rst_no = (state_q == RUN);
  assign ready_o    = (state_q == RUN);
  assign pll_lock_o = pll_lock_q;
  assign boot_sel_o = boot_sel_q;

endmodule

// File: tb/tb_azadi_rst_boot_ctrl.sv
// Scoreboard bench for azadi_rst_boot_ctrl: expected output transitions queued with their cycle numbers.
module tb_azadi_rst_boot_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rst_req_i;
  logic       pll_lock_i;
  logic [1:0] boot_sel_i;
  logic       sys_rst_no;
  logic       pll_lock_o;
  logic [1:0] boot_sel_o;
  logic       ready_o;
  logic [1:0] rst_cause_o;

  azadi_rst_boot_ctrl #(
    .SYNC_STAGES(2),
    .LOCK_FILTER(16),
    .RST_HOLD   (32)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rst_req_i  (rst_req_i),
    .pll_lock_i (pll_lock_i),
    .boot_sel_i (boot_sel_i),
    .sys_rst_no (sys_rst_no),
    .pll_lock_o (pll_lock_o),
    .boot_sel_o (boot_sel_o),
    .ready_o    (ready_o),
    .rst_cause_o(rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    int         cyc;
    logic       rstn;
    logic       pll;
    logic [1:0] bsel;
    logic [1:0] cause;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   passed  = 0;
  logic [6:0] cur;
  logic [6:0] prev;
  exp_t e;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [1:0] cz(input logic [1:0] c);
`ifdef RST_CAUSE_EN
    return c;
`else
    return 2'b00;
`endif
  endfunction

  task automatic expect_at(input string n, input int c, input logic rn, input logic pl,
                           input logic [1:0] bs, input logic [1:0] ca);
    exp_t x;
    x.name = n; x.cyc = c; x.rstn = rn; x.pll = pl; x.bsel = bs; x.cause = ca;
    exp_q.push_back(x);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // Monitor: any output change (and the first post-reset sample) consumes one expected entry.
  always @(negedge clk_i) begin
    cur = {sys_rst_no, ready_o, pll_lock_o, boot_sel_o, rst_cause_o};
    if (cyc == 1 || (cyc > 1 && cur != prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change: cyc=%0d rstn=%b rdy=%b pll=%b bsel=%b cause=%b, expected no change",
                 cyc, sys_rst_no, ready_o, pll_lock_o, boot_sel_o, rst_cause_o);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == cyc && sys_rst_no === e.rstn && ready_o === e.rstn &&
            pll_lock_o === e.pll && boot_sel_o === e.bsel && rst_cause_o === e.cause) begin
          passed++;
        end else begin
          $display("FAIL %s: cyc=%0d rstn=%b rdy=%b pll=%b bsel=%b cause=%b, expected cyc=%0d rstn=%b pll=%b bsel=%b cause=%b",
                   e.name, cyc, sys_rst_no, ready_o, pll_lock_o, boot_sel_o, rst_cause_o,
                   e.cyc, e.rstn, e.pll, e.bsel, e.cause);
        end
      end
    end
    prev = cur;
  end

  initial begin
    rst_i      = 1'b1;
    rst_req_i  = 1'b0;
    pll_lock_i = 1'b1;
    boot_sel_i = 2'b10;
    expect_at("reset", 1, 1'b0, 1'b0, 2'b00, 2'b00);

    // Power-up: 4 reset edges, lock high throughout.
    wait_cyc(4);
    rst_i = 1'b0;
    expect_at("lock_up", 23, 1'b0, 1'b1, 2'b00, 2'b00);
    expect_at("release", 56, 1'b1, 1'b1, 2'b10, 2'b00);

    // Boot select change during RUN must not reach boot_sel_o.
    wait_cyc(60);
    boot_sel_i = 2'b01;

    // 3-cycle reset request in RUN.
    wait_cyc(70);
    rst_req_i = 1'b1;
    expect_at("req_assert", 73, 1'b0, 1'b1, 2'b10, cz(2'b01));
    expect_at("req_release", 108, 1'b1, 1'b1, 2'b01, cz(2'b01));
    wait_cyc(73);
    rst_req_i = 1'b0;

    // Lock loss in RUN.
    wait_cyc(120);
    pll_lock_i = 1'b0;
    expect_at("lock_drop", 123, 1'b1, 1'b0, 2'b01, cz(2'b01));
    expect_at("loss_assert", 124, 1'b0, 1'b0, 2'b01, cz(2'b10));

    // Lock glitch: high 10, low 1, then high; filter restarts.
    wait_cyc(130);
    pll_lock_i = 1'b1;
    wait_cyc(140);
    pll_lock_i = 1'b0;
    wait_cyc(141);
    pll_lock_i = 1'b1;
    expect_at("glitch_relock", 160, 1'b0, 1'b1, 2'b01, cz(2'b10));
    expect_at("glitch_release", 193, 1'b1, 1'b1, 2'b01, cz(2'b10));

    // Simultaneous request and lock loss in RUN.
    wait_cyc(200);
    rst_req_i  = 1'b1;
    pll_lock_i = 1'b0;
    expect_at("both_assert", 203, 1'b0, 1'b0, 2'b01, cz(2'b11));
    wait_cyc(210);
    rst_req_i  = 1'b0;
    pll_lock_i = 1'b1;
    expect_at("both_relock", 229, 1'b0, 1'b1, 2'b01, cz(2'b11));
    expect_at("both_release", 262, 1'b1, 1'b1, 2'b01, cz(2'b11));

    // Minimum 2-cycle request to enter HOLD, then rst_i at hold count 20.
    wait_cyc(270);
    rst_req_i = 1'b1;
    expect_at("hold_entry", 273, 1'b0, 1'b1, 2'b01, cz(2'b01));
    wait_cyc(272);
    rst_req_i = 1'b0;
    wait_cyc(295);
    rst_i = 1'b1;
    expect_at("mid_hold_rst", 296, 1'b0, 1'b0, 2'b00, 2'b00);
    wait_cyc(296);
    rst_i = 1'b0;
    expect_at("rerun_lock", 315, 1'b0, 1'b1, 2'b00, 2'b00);
    expect_at("rerun_release", 348, 1'b1, 1'b1, 2'b01, 2'b00);

    wait_cyc(360);
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL pending_events: %0d left, next %s at cyc %0d, required 0 left",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
